waveform_capture_pretrig: RTL and testbench

- Parametrised successor to the single-shot trigger capture block.
- Continuously records ADC samples into a circular buffer, so a capture holds a configurable number of pre-trigger samples.
- Captures on a trigger rising edge, then streams the frozen waveform out oldest-first over a valid/ready handshake to the UART packetiser.
- Re-arms automatically after each readout; counts completed and missed triggers.

---
 rtl/waveform_capture_pretrig_if.sv | 24 ++
 rtl/waveform_capture_pretrig.sv | 197 +++++++++++++++++++
 tb/tb_waveform_capture_pretrig.sv | 328 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/waveform_capture_pretrig_if.sv
// Readout stream interface: sample words with valid/ready and
// an end-of-waveform marker.
interface waveform_capture_pretrig_if #(
  parameter int DATA_W = 14
);
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              rd_ready;
  logic              rd_last;

  modport master (
    output rd_data,
    output rd_valid,
    output rd_last,
    input  rd_ready
  );

  modport slave (
    input  rd_data,
    input  rd_valid,
    input  rd_last,
    output rd_ready
  );
endinterface

// File: rtl/waveform_capture_pretrig.sv
// Circular-buffer ADC capture with a pre-trigger window, streamed out
// oldest-first. Optional macro HEADER_WORD_EN: prepend capture index.
module waveform_capture_pretrig #(
  parameter int DATA_W      = 14,
  parameter int DEPTH       = 2000,
  parameter int PRE_SAMPLES = 200,
  parameter int CNT_W       = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [DATA_W-1:0]         signal,
  input  logic                      trigger_in,
  waveform_capture_pretrig_if.master rd,
  output logic                      busy,
  output logic [CNT_W-1:0]          wave_number,
  output logic [CNT_W-1:0]          missed_triggers
);

`ifdef HEADER_WORD_EN
  localparam int HDR = 1;
`else
  localparam int HDR = 0;
`endif
  localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int POST_N = DEPTH - PRE_SAMPLES - 1;
  localparam int TOTAL  = DEPTH + HDR;
  localparam int IW     = $clog2(TOTAL + 1);

  typedef enum logic [1:0] {
    S_FILL,
    S_ARMED,
    S_POST,
    S_READOUT
  } state_t;

  // With no pre-trigger span there is nothing to fill
  localparam state_t S_START =
    (PRE_SAMPLES == 0) ? S_ARMED : S_FILL;

  state_t            r_state;
  state_t            w_nxt;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_trig_ptr;
  logic [AW-1:0]     r_rd_addr;
  logic [AW-1:0]     r_cnt;
  logic [IW-1:0]     r_idx;
  logic              r_trig_q;
  logic [CNT_W-1:0]  r_wave;
  logic [CNT_W-1:0]  r_missed;
  logic [DATA_W-1:0] r_rd_data;
  logic              r_valid;
  logic              r_last;
  logic              w_edge;
  logic              w_we;
  logic              w_cap;
  logic              w_enter;
  logic              w_rd_en;
  logic              w_hdr_sel;
  logic [AW-1:0]     w_tp;
  logic [AW:0]       w_sum;
  logic [AW-1:0]     w_start;

  function automatic logic [AW-1:0] f_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign w_edge = trigger_in & ~r_trig_q;

  // Window start: trigger slot minus the pre-trigger span, mod DEPTH.
  // When POST is empty the trigger slot is still the live write pointer.
  assign w_tp    = (r_state == S_ARMED) ? r_wr_ptr : r_trig_ptr;
  assign w_sum   = {1'b0, w_tp} + (AW+1)'(DEPTH - PRE_SAMPLES);
  assign w_start = (w_sum >= (AW+1)'(DEPTH))
                 ? AW'(w_sum - (AW+1)'(DEPTH))
                 : AW'(w_sum);

`ifdef HEADER_WORD_EN
  assign w_hdr_sel = (r_idx == '0);
`else
  assign w_hdr_sel = 1'b0;
`endif

  // Next state and per-cycle strobes
  always_comb begin
    w_nxt   = r_state;
    w_we    = 1'b0;
    w_cap   = 1'b0;
    w_enter = 1'b0;
    w_rd_en = 1'b0;
    unique case (r_state)
      S_FILL: begin
        w_we = 1'b1;
        if (r_cnt == AW'(PRE_SAMPLES - 1))
          w_nxt = S_ARMED;
      end
      S_ARMED: begin
        w_we = 1'b1;
        if (w_edge) begin
          w_cap = 1'b1;
          if (POST_N == 0) begin
            w_nxt   = S_READOUT;
            w_enter = 1'b1;
          end else begin
            w_nxt = S_POST;
          end
        end
      end
      S_POST: begin
        w_we = 1'b1;
        if (r_cnt == AW'(POST_N - 1)) begin
          w_nxt   = S_READOUT;
          w_enter = 1'b1;
        end
      end
      S_READOUT: begin
        w_rd_en = (r_idx != IW'(TOTAL))
                && (!r_valid || rd.rd_ready);
        if (r_valid && rd.rd_ready && r_last)
          w_nxt = S_START;
      end
      default: w_nxt = S_START;
    endcase
  end

  // State, pointers and counters
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_START;
      r_wr_ptr   <= '0;
      r_trig_ptr <= '0;
      r_rd_addr  <= '0;
      r_cnt      <= '0;
      r_idx      <= '0;
      r_wave     <= '0;
      r_missed   <= '0;
    end else begin
      r_state <= w_nxt;
      if (w_nxt != r_state)
        r_cnt <= '0;
      else if (r_state == S_FILL || r_state == S_POST)
        r_cnt <= r_cnt + 1'b1;
      if (w_we)
        r_wr_ptr <= f_inc(r_wr_ptr);
      if (w_cap)
        r_trig_ptr <= r_wr_ptr;
      if (w_enter) begin
        r_rd_addr <= w_start;
        r_idx     <= '0;
        r_wave    <= r_wave + 1'b1;
      end else if (w_rd_en) begin
        r_idx <= r_idx + 1'b1;
        if (!w_hdr_sel)
          r_rd_addr <= f_inc(r_rd_addr);
      end
      if (w_edge && r_state != S_ARMED && r_missed != '1)
        r_missed <= r_missed + 1'b1;
    end
  end

  // History tracks the level even in reset: a held trigger is no edge
  always_ff @(posedge clk) begin
    r_trig_q <= trigger_in;
  end

  // Sample buffer write port
  always_ff @(posedge clk) begin
    if (w_we && !reset)
      r_mem[r_wr_ptr] <= signal;
  end

  // Registered read port doubling as the output stage
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_data <= '0;
      r_valid   <= 1'b0;
      r_last    <= 1'b0;
    end else if (w_rd_en) begin
      r_rd_data <= w_hdr_sel ? DATA_W'(r_wave)
                             : r_mem[r_rd_addr];
      r_valid   <= 1'b1;
      r_last    <= (r_idx == IW'(TOTAL - 1));
    end else if (rd.rd_ready) begin
      r_valid <= 1'b0;
      r_last  <= 1'b0;
    end
  end

  assign rd.rd_data      = r_rd_data;
  assign rd.rd_valid     = r_valid;
  assign rd.rd_last      = r_last;
  assign busy            = (r_state == S_POST)
                        || (r_state == S_READOUT);
  assign wave_number     = r_wave;
  assign missed_triggers = r_missed;

endmodule

// File: tb/tb_waveform_capture_pretrig.sv
// Bench for waveform_capture_pretrig: directed ramp captures on two
// configurations plus a randomized run against a sample-log model.
module tb_waveform_capture_pretrig;

`ifdef HEADER_WORD_EN
  localparam int HDR = 1;
`else
  localparam int HDR = 0;
`endif
  localparam int TOT  = 16 + HDR;
  localparam int RD   = 13;
  localparam int RP   = 5;
  localparam int RPN  = RD - RP - 1;
  localparam int RTOT = RD + HDR;

  logic clk;
  logic [2:0]       rst;
  logic [2:0]       trg;
  logic [2:0]       rdy;
  logic [2:0][13:0] sig;
  logic [2:0][13:0] o_data;
  logic [2:0]       o_valid;
  logic [2:0]       o_last;
  logic [2:0]       o_busy;
  logic [2:0][15:0] o_wave;
  logic [2:0][15:0] o_miss;

  int n_tests = 0;
  int n_fail  = 0;

  waveform_capture_pretrig_if #(.DATA_W(14)) bus0 ();
  waveform_capture_pretrig_if #(.DATA_W(14)) bus1 ();
  waveform_capture_pretrig_if #(.DATA_W(14)) bus2 ();

  assign bus0.rd_ready = rdy[0];
  assign bus1.rd_ready = rdy[1];
  assign bus2.rd_ready = rdy[2];
  assign o_data[0]  = bus0.rd_data;
  assign o_data[1]  = bus1.rd_data;
  assign o_data[2]  = bus2.rd_data;
  assign o_valid[0] = bus0.rd_valid;
  assign o_valid[1] = bus1.rd_valid;
  assign o_valid[2] = bus2.rd_valid;
  assign o_last[0]  = bus0.rd_last;
  assign o_last[1]  = bus1.rd_last;
  assign o_last[2]  = bus2.rd_last;

  waveform_capture_pretrig #(
    .DATA_W(14), .DEPTH(16), .PRE_SAMPLES(4), .CNT_W(16)
  ) u0 (
    .clk(clk), .reset(rst[0]), .signal(sig[0]),
    .trigger_in(trg[0]), .rd(bus0.master), .busy(o_busy[0]),
    .wave_number(o_wave[0]), .missed_triggers(o_miss[0])
  );

  waveform_capture_pretrig #(
    .DATA_W(14), .DEPTH(16), .PRE_SAMPLES(0), .CNT_W(16)
  ) u1 (
    .clk(clk), .reset(rst[1]), .signal(sig[1]),
    .trigger_in(trg[1]), .rd(bus1.master), .busy(o_busy[1]),
    .wave_number(o_wave[1]), .missed_triggers(o_miss[1])
  );

  waveform_capture_pretrig #(
    .DATA_W(14), .DEPTH(RD), .PRE_SAMPLES(RP), .CNT_W(16)
  ) u2 (
    .clk(clk), .reset(rst[2]), .signal(sig[2]),
    .trigger_in(trg[2]), .rd(bus2.master), .busy(o_busy[2]),
    .wave_number(o_wave[2]), .missed_triggers(o_miss[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int dut;
    int miss_at;
    int trig_at;
    int trig2;
    bit stall;
    int first;
    int first2;
    int wave;
    int missed;
  } vec_t;

  vec_t vt [6];

  task automatic chk(input string nm, input longint act,
                     input longint exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic run_dir(input int ci, input vec_t v);
    int d;
    int n_exp;
    int words[$];
    bit lasts[$];
    bit prev_stall;
    logic [13:0] prev_d;
    int idx;
    int first;
    d = v.dut;
    n_exp = (v.trig2 != 0) ? 2 * TOT : TOT;
    rst[d] = 1'b1;
    trg[d] = 1'b0;
    sig[d] = '0;
    rdy[d] = 1'b1;
    repeat (2) @(negedge clk);
    rst[d] = 1'b0;
    prev_stall = 1'b0;
    prev_d = '0;
    for (int t = 0; t < 400 && words.size() < n_exp; t++) begin
      sig[d] = 14'(t);
      trg[d] = (t == v.trig_at) || (t == v.miss_at)
            || (v.trig2 != 0 && t == v.trig2);
      rdy[d] = v.stall ? (t % 4 == 0 || t % 4 == 3) : 1'b1;
      if (prev_stall) begin
        chk($sformatf("c%0d_hold_valid", ci), o_valid[d], 1);
        chk($sformatf("c%0d_hold_data", ci), o_data[d], prev_d);
      end
      if (o_valid[d] && rdy[d]) begin
        words.push_back(int'(o_data[d]));
        lasts.push_back(o_last[d]);
      end
      prev_stall = o_valid[d] && !rdy[d];
      prev_d = o_data[d];
      @(negedge clk);
    end
    chk($sformatf("c%0d_nwords", ci), words.size(), n_exp);
    for (int c = 0; c < n_exp / TOT; c++) begin
      first = (c == 0) ? v.first : v.first2;
`ifdef HEADER_WORD_EN
      if (c * TOT < words.size()) begin
        chk($sformatf("c%0d_hdr%0d", ci, c), words[c*TOT], c + 1);
        chk($sformatf("c%0d_hdrlast%0d", ci, c), lasts[c*TOT], 0);
      end
`endif
      for (int j = 0; j < 16; j++) begin
        idx = c * TOT + HDR + j;
        if (idx < words.size()) begin
          chk($sformatf("c%0d_word%0d", ci, idx), words[idx],
              first + j);
          chk($sformatf("c%0d_last%0d", ci, idx), lasts[idx],
              j == 15);
        end
      end
    end
    chk($sformatf("c%0d_wave", ci), o_wave[d], v.wave);
    chk($sformatf("c%0d_missed", ci), o_miss[d], v.missed);
    rst[d] = 1'b1;
    trg[d] = 1'b0;
    @(negedge clk);
  endtask

  task automatic run_abort();
    int got;
    rst[0] = 1'b1;
    trg[0] = 1'b0;
    rdy[0] = 1'b1;
    repeat (2) @(negedge clk);
    rst[0] = 1'b0;
    got = 0;
    for (int t = 0; t < 200 && got < 5; t++) begin
      sig[0] = 14'(t);
      trg[0] = (t == 20);
      if (o_valid[0] && rdy[0]) begin
        if (got == 0)
          chk("wrap_first", o_data[0], (HDR == 1) ? 1 : 16);
        got++;
      end
      @(negedge clk);
    end
    chk("abort_reached", got, 5);
    chk("abort_busy_before", o_busy[0], 1);
    rst[0] = 1'b1;
    @(negedge clk);
    chk("abort_valid", o_valid[0], 0);
    chk("abort_last", o_last[0], 0);
    chk("abort_wave", o_wave[0], 0);
    chk("abort_busy", o_busy[0], 0);
    trg[0] = 1'b1;
    @(negedge clk);
    rst[0] = 1'b0;
    for (int t = 0; t < 40; t++) begin
      sig[0] = 14'(t);
      @(negedge clk);
    end
    chk("held_trig_busy", o_busy[0], 0);
    chk("held_trig_missed", o_miss[0], 0);
    chk("held_trig_wave", o_wave[0], 0);
    rst[0] = 1'b1;
    trg[0] = 1'b0;
    @(negedge clk);
  endtask

  task automatic run_random();
    int ph;
    int fill_left;
    int post_left;
    int ro_left;
    int missed;
    int wave;
    int logq[$];
    int expq[$];
    bit pt;
    rst[2] = 1'b1;
    trg[2] = 1'b0;
    rdy[2] = 1'b1;
    repeat (2) @(negedge clk);
    rst[2] = 1'b0;
    ph = (RP == 0) ? 1 : 0;
    fill_left = RP;
    post_left = 0;
    ro_left = 0;
    missed = 0;
    wave = 0;
    pt = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      int s;
      bit t;
      bit r;
      bit e;
      bit acc;
      bit enter;
      chk("rnd_busy", o_busy[2], ph >= 2);
      s = $urandom_range(0, 16383);
      r = ($urandom_range(0, 3) != 0);
      t = ($urandom_range(0, 5) == 0) ? ~pt : pt;
      acc = o_valid[2] && r;
      if (acc) begin
        if (ph != 3 || expq.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL rnd_unexpected_word: got %0d expected none",
                   o_data[2]);
        end else begin
          chk("rnd_data", o_data[2], expq.pop_front());
          chk("rnd_last", o_last[2], ro_left == 1);
        end
      end
      e = t & ~pt;
      pt = t;
      enter = 1'b0;
      if (ph == 3) begin
        if (e) missed++;
        if (acc) begin
          ro_left--;
          if (ro_left == 0) begin
            fill_left = RP;
            ph = (RP == 0) ? 1 : 0;
          end
        end
      end else begin
        logq.push_back(s);
        if (logq.size() > RD) void'(logq.pop_front());
        if (ph == 0) begin
          if (e) missed++;
          fill_left--;
          if (fill_left == 0) ph = 1;
        end else if (ph == 1) begin
          if (e) begin
            post_left = RPN;
            if (RPN == 0) enter = 1'b1;
            else ph = 2;
          end
        end else begin
          if (e) missed++;
          post_left--;
          if (post_left == 0) enter = 1'b1;
        end
      end
      if (enter) begin
        ph = 3;
        wave++;
        ro_left = RTOT;
        expq.delete();
        if (HDR == 1) expq.push_back(wave & 16383);
        foreach (logq[i]) expq.push_back(logq[i]);
      end
      sig[2] = 14'(s);
      trg[2] = t;
      rdy[2] = r;
      @(negedge clk);
    end
    chk("rnd_wave", o_wave[2], wave);
    chk("rnd_missed", o_miss[2], missed);
  endtask

  initial begin
    vt[0] = '{dut:0, miss_at:-1, trig_at:30, trig2:0, stall:0,
              first:26, first2:0, wave:1, missed:0};
    vt[1] = '{dut:0, miss_at:2, trig_at:30, trig2:0, stall:0,
              first:26, first2:0, wave:1, missed:1};
    vt[2] = '{dut:1, miss_at:-1, trig_at:10, trig2:0, stall:0,
              first:10, first2:0, wave:1, missed:0};
    vt[3] = '{dut:0, miss_at:-1, trig_at:30, trig2:0, stall:1,
              first:26, first2:0, wave:1, missed:0};
    vt[4] = '{dut:0, miss_at:-1, trig_at:20, trig2:0, stall:0,
              first:16, first2:0, wave:1, missed:0};
    vt[5] = '{dut:0, miss_at:-1, trig_at:30, trig2:80, stall:0,
              first:26, first2:76, wave:2, missed:0};
    rst = '1;
    trg = '0;
    rdy = '1;
    sig = '0;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("rst%0d_data", d), o_data[d], 0);
      chk($sformatf("rst%0d_valid", d), o_valid[d], 0);
      chk($sformatf("rst%0d_last", d), o_last[d], 0);
      chk($sformatf("rst%0d_busy", d), o_busy[d], 0);
      chk($sformatf("rst%0d_wave", d), o_wave[d], 0);
      chk($sformatf("rst%0d_miss", d), o_miss[d], 0);
    end
    for (int i = 0; i < 6; i++)
      run_dir(i, vt[i]);
    run_abort();
    run_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
